// File: rtl/sram16_ctrl.sv
// sram16_ctrl: serves 32-bit CPU word requests as two 16-bit cycles on one async SRAM,
// low half first, with every SRAM pin driven from a register.
module sram16_ctrl #(
    parameter int unsigned AWIDTH = 18,
    parameter int unsigned WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [29:0]       memaddr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_be,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic [AWIDTH-1:0] sram_a,
    input  logic [15:0]       sram_io_in,
    output logic [15:0]       sram_io_out,
    output logic              sram_io_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StDone} state_e;

    localparam logic [3:0] PulseLast = 4'(WAIT - 1);

    state_e            state_q, state_d;
    logic              hi_q, hi_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [AWIDTH-2:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              more;

    logic [AWIDTH-1:0] a_d;
    logic [15:0]       io_out_d;
    logic              io_oe_d, ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d, ack_d;
    logic              capture;

    // Upper word-address bits alias onto the same SRAM location.
    logic unused_addr;
    assign unused_addr = ^memaddr[29:AWIDTH-1];

    // A second (high) halfword is still owed after the current one.
    assign more    = !hi_q && (!wr_q || (be_q[3:2] != 2'b00));
    assign capture = (state_q == StPulse) && (cnt_q == 4'd0) && !wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hi_q    <= 1'b0;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        unique case (state_q)
            StIdle: begin
                if (mem_we || mem_re) begin
                    wr_d    = mem_we;
                    addr_d  = memaddr[AWIDTH-2:0];
                    wdata_d = mem_wdata;
                    be_d    = mem_be;
                    hi_d    = mem_we && (mem_be[1:0] == 2'b00);
                    cnt_d   = 4'd0;
                    state_d = (mem_we && (mem_be == 4'h0)) ? StDone : StSetup;
                end
            end
            StSetup: begin
                cnt_d   = PulseLast;
                state_d = StPulse;
            end
            StPulse: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (wr_q) begin
                    state_d = StHold;
                end else begin
                    hi_d    = hi_q | more;
                    state_d = more ? StSetup : StDone;
                end
            end
            StHold: begin
                hi_d    = hi_q | more;
                state_d = more ? StSetup : StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pin values are decoded from the next state so they line up with the state register.
    always_comb begin
        a_d      = sram_a;
        io_out_d = sram_io_out;
        io_oe_d  = 1'b0;
        ce_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        lb_n_d   = 1'b1;
        ub_n_d   = 1'b1;
        ack_d    = (state_d == StDone);
        if ((state_d == StSetup) || (state_d == StPulse) || (state_d == StHold)) begin
            ce_n_d = 1'b0;
            a_d    = {addr_d, hi_d};
            if (wr_d) begin
                io_oe_d  = 1'b1;
                io_out_d = hi_d ? wdata_d[31:16] : wdata_d[15:0];
                lb_n_d   = ~(hi_d ? be_d[2] : be_d[0]);
                ub_n_d   = ~(hi_d ? be_d[3] : be_d[1]);
            end else begin
                lb_n_d = 1'b0;
                ub_n_d = 1'b0;
            end
            if (state_d == StPulse) begin
                if (wr_d) begin
                    we_n_d = 1'b0;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_a      <= '0;
            sram_io_out <= 16'h0000;
            sram_io_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            mem_ack     <= 1'b0;
            mem_rdata   <= 32'h0;
        end else begin
            sram_a      <= a_d;
            sram_io_out <= io_out_d;
            sram_io_oe  <= io_oe_d;
            sram_ce_n   <= ce_n_d;
            sram_oe_n   <= oe_n_d;
            sram_we_n   <= we_n_d;
            sram_lb_n   <= lb_n_d;
            sram_ub_n   <= ub_n_d;
            mem_ack     <= ack_d;
            if (capture) begin
                if (hi_q) begin
                    mem_rdata[31:16] <= sram_io_in;
                end else begin
                    mem_rdata[15:0] <= sram_io_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram16_ctrl.sv
// tb_sram16_ctrl: directed checks of sram16_ctrl against a small async SRAM model.
module tb_sram16_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_re = 1'b0;
    logic        mem_we = 1'b0;
    logic [29:0] memaddr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_be = '0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [17:0] sram_a;
    logic [15:0] sram_io_in;
    logic [15:0] sram_io_out;
    logic        sram_io_oe;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    sram16_ctrl #(
        .AWIDTH(18),
        .WAIT  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .memaddr    (memaddr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .sram_a     (sram_a),
        .sram_io_in (sram_io_in),
        .sram_io_out(sram_io_out),
        .sram_io_oe (sram_io_oe),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ub_n  (sram_ub_n)
    );

    always #5 clk = ~clk;

    // Async SRAM model: write latched on the rising edge of we_n.
    logic [15:0] mem [0:255];
    assign sram_io_in = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0 && sram_io_oe === 1'b0)
                        ? mem[sram_a[7:0]] : 16'h0000;
    always @(posedge sram_we_n) begin
        if (sram_ce_n === 1'b0 && sram_io_oe === 1'b1) begin
            if (sram_lb_n === 1'b0) mem[sram_a[7:0]][7:0] = sram_io_out[7:0];
            if (sram_ub_n === 1'b0) mem[sram_a[7:0]][15:8] = sram_io_out[15:8];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Strobe monitor: one queue entry per low pulse of we_n or oe_n.
    logic        mon_en = 1'b0;
    logic        prev_lo = 1'b0;
    int          ce_lo_cnt, we_lo_cnt, oe_lo_cnt, unstable, ack_cnt = 0;
    logic [17:0] pa [$];
    logic [15:0] pd [$];
    logic [1:0]  pl [$];
    int          plen [$];

    always @(negedge clk) begin
        if (mem_ack === 1'b1) ack_cnt++;
        if (mon_en) begin
            if (!sram_ce_n) ce_lo_cnt++;
            if (!sram_we_n) we_lo_cnt++;
            if (!sram_oe_n) oe_lo_cnt++;
            if (!sram_we_n || !sram_oe_n) begin
                if (!prev_lo) begin
                    pa.push_back(sram_a);
                    pd.push_back(sram_io_out);
                    pl.push_back({sram_ub_n, sram_lb_n});
                    plen.push_back(1);
                end else begin
                    plen[plen.size()-1] = plen[plen.size()-1] + 1;
                    if (sram_a != pa[pa.size()-1] || sram_io_out != pd[pd.size()-1]
                        || {sram_ub_n, sram_lb_n} != pl[pl.size()-1]) unstable++;
                end
            end
            prev_lo = !sram_we_n || !sram_oe_n;
        end
    end

    function automatic logic [31:0] q_a(int i);
        return (i < pa.size()) ? 32'(pa[i]) : 32'hffff_ffff;
    endfunction
    function automatic logic [31:0] q_d(int i);
        return (i < pd.size()) ? 32'(pd[i]) : 32'hffff_ffff;
    endfunction
    function automatic logic [31:0] q_l(int i);
        return (i < pl.size()) ? 32'(pl[i]) : 32'hffff_ffff;
    endfunction
    function automatic logic [31:0] q_len(int i);
        return (i < plen.size()) ? 32'(plen[i]) : 32'hffff_ffff;
    endfunction

    logic        chg_en = 1'b0;
    logic [29:0] chg_addr = '0;

    // Issue one request at a falling edge; lat counts cycles after the sampling edge.
    task automatic run_req(input logic we, input logic re, input logic [29:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, output int lat);
        @(negedge clk);
        pa.delete(); pd.delete(); pl.delete(); plen.delete();
        ce_lo_cnt = 0; we_lo_cnt = 0; oe_lo_cnt = 0; unstable = 0; prev_lo = 1'b0;
        mon_en = 1'b1;
        mem_we = we; mem_re = re; memaddr = addr; mem_wdata = wd; mem_be = be;
        lat = 0;
        while (lat < 60 && mem_ack !== 1'b1) begin
            @(negedge clk);
            lat++;
            if (lat == 3 && chg_en) memaddr = chg_addr;
        end
        check_val("ack_seen", 32'(mem_ack), 32'd1);
        mem_we = 1'b0; mem_re = 1'b0;
        mon_en = 1'b0;
    endtask

    int lat;
    logic found;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // Reset held three cycles, then idle.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_val("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}),
                  32'h1f);
        check_val("rst_io_oe", 32'(sram_io_oe), 32'd0);
        check_val("rst_rdata", mem_rdata, 32'h0);
        check_val("rst_addr", 32'(sram_a), 32'd0);
        repeat (4) @(negedge clk);
        check_val("idle_no_ack", 32'(ack_cnt), 32'd0);
        check_val("idle_ce_n", 32'(sram_ce_n), 32'd1);

        // Full write of 0xDEADBEEF to word 5.
        run_req(1'b1, 1'b0, 30'd5, 32'hDEAD_BEEF, 4'hF, lat);
        check_val("wr_lat", 32'(lat), 32'd9);
        check_val("wr_npulse", 32'(pa.size()), 32'd2);
        check_val("wr_a0", q_a(0), 32'd10);
        check_val("wr_a1", q_a(1), 32'd11);
        check_val("wr_d0", q_d(0), 32'hBEEF);
        check_val("wr_d1", q_d(1), 32'hDEAD);
        check_val("wr_len0", q_len(0), 32'd2);
        check_val("wr_len1", q_len(1), 32'd2);
        check_val("wr_lanes0", q_l(0), 32'd0);
        check_val("wr_ce_cycles", 32'(ce_lo_cnt), 32'd8);
        check_val("wr_stable", 32'(unstable), 32'd0);
        check_val("wr_mem10", 32'(mem[10]), 32'hBEEF);
        check_val("wr_mem11", 32'(mem[11]), 32'hDEAD);

        // Read back word 5.
        run_req(1'b0, 1'b1, 30'd5, 32'h0, 4'h0, lat);
        check_val("rd_lat", 32'(lat), 32'd7);
        check_val("rd_we_cycles", 32'(we_lo_cnt), 32'd0);
        check_val("rd_oe_cycles", 32'(oe_lo_cnt), 32'd4);
        check_val("rd_len0", q_len(0), 32'd2);
        check_val("rd_len1", q_len(1), 32'd2);
        check_val("rd_ce_cycles", 32'(ce_lo_cnt), 32'd6);
        check_val("rd_data", mem_rdata, 32'hDEAD_BEEF);

        // Single-byte write to byte 2: only the high halfword, low lane.
        run_req(1'b1, 1'b0, 30'd5, 32'h00AA_0000, 4'h4, lat);
        check_val("be4_lat", 32'(lat), 32'd5);
        check_val("be4_npulse", 32'(pa.size()), 32'd1);
        check_val("be4_a", q_a(0), 32'd11);
        check_val("be4_lanes", q_l(0), 32'b10);
        check_val("be4_mem11", 32'(mem[11]), 32'hDEAA);
        run_req(1'b0, 1'b1, 30'd5, 32'h0, 4'h0, lat);
        check_val("be4_rd", mem_rdata, 32'hDEAA_BEEF);

        // No byte enables: immediate ack, SRAM untouched.
        run_req(1'b1, 1'b0, 30'd5, 32'h1111_1111, 4'h0, lat);
        check_val("be0_lat", 32'(lat), 32'd1);
        check_val("be0_ce_cycles", 32'(ce_lo_cnt), 32'd0);
        check_val("be0_mem10", 32'(mem[10]), 32'hBEEF);

        // Both strobes high: write wins; address change mid-transaction is ignored.
        chg_en = 1'b1; chg_addr = 30'd9;
        run_req(1'b1, 1'b1, 30'd7, 32'h1234_5678, 4'hF, lat);
        chg_en = 1'b0;
        check_val("both_lat", 32'(lat), 32'd9);
        check_val("both_a0", q_a(0), 32'd14);
        check_val("both_a1", q_a(1), 32'd15);
        check_val("both_mem14", 32'(mem[14]), 32'h5678);
        check_val("both_mem15", 32'(mem[15]), 32'h1234);
        check_val("both_mem18", 32'(mem[18]), 32'h0000);
        check_val("wr_keeps_rdata", mem_rdata, 32'hDEAA_BEEF);

        // Restore word 5, then reset during the high-half read pulse.
        run_req(1'b1, 1'b0, 30'd5, 32'hDEAD_BEEF, 4'hF, lat);
        @(negedge clk);
        mem_re = 1'b1; memaddr = 30'd5;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (sram_a == 18'd11 && sram_oe_n == 1'b0) found = 1'b1;
        end
        check_val("rst_mid_found", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_mid_strobes",
                  32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 32'h1f);
        check_val("rst_mid_ack", 32'(mem_ack), 32'd0);
        rst = 1'b0; mem_re = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_mid_idle", 32'(sram_ce_n), 32'd1);
        run_req(1'b0, 1'b1, 30'd5, 32'h0, 4'h0, lat);
        check_val("reissue_lat", 32'(lat), 32'd7);
        check_val("reissue_data", mem_rdata, 32'hDEAD_BEEF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
